// File: rtl/conv_pkg.sv
// ============================================================================
// Module : conv_pkg
// Brief  : Shared constants and helpers for the 3x3 convolution window path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package conv_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int KERNEL_SIZE        = 3;

    // Window output order, row-major with 0 at top-left.
    localparam int WIN_TL = 0;
    localparam int WIN_TC = 1;
    localparam int WIN_TR = 2;
    localparam int WIN_ML = 3;
    localparam int WIN_MC = 4;
    localparam int WIN_MR = 5;
    localparam int WIN_BL = 6;
    localparam int WIN_BC = 7;
    localparam int WIN_BR = 8;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/conv_line_buffer.sv
// ============================================================================
// Module : conv_line_buffer
// Brief  : One-row delay line; asynchronous read of the old word, write after.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module conv_line_buffer
    import conv_pkg::*;
#(
    parameter int DEPTH = 28,
    parameter int WIDTH = DEFAULT_DATA_WIDTH,
    parameter int AW    = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/conv_window_3x3_gen.sv
// ============================================================================
// Module : conv_window_3x3_gen
// Brief  : Streaming 3x3 window generator; CONV_WINDOW_STRIDE2_EN selects stride 2.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module conv_window_3x3_gen
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] Data_In,
    input  logic                  Valid_In,
    output logic [DATA_WIDTH-1:0] Window0,
    output logic [DATA_WIDTH-1:0] Window1,
    output logic [DATA_WIDTH-1:0] Window2,
    output logic [DATA_WIDTH-1:0] Window3,
    output logic [DATA_WIDTH-1:0] Window4,
    output logic [DATA_WIDTH-1:0] Window5,
    output logic [DATA_WIDTH-1:0] Window6,
    output logic [DATA_WIDTH-1:0] Window7,
    output logic [DATA_WIDTH-1:0] Window8,
    output logic                  Valid_Out,
    output logic                  Frame_Done
);

    localparam int CW = cnt_width(IMG_WIDTH);
    localparam int RW = cnt_width(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(KERNEL_SIZE - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(KERNEL_SIZE - 1);

    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic [DATA_WIDTH-1:0] lb0_rd;
    logic [DATA_WIDTH-1:0] lb1_rd;
    logic                  wr_en;
    logic                  issue;
    logic                  last_pix;
    logic [DATA_WIDTH-1:0] new_col [KERNEL_SIZE];
    // Two older columns; the incoming column completes the 3x3 view.
    logic [DATA_WIDTH-1:0] sr      [KERNEL_SIZE-1][KERNEL_SIZE];
    logic [DATA_WIDTH-1:0] win     [KERNEL_SIZE*KERNEL_SIZE];

    assign wr_en = Valid_In && !rst;

    conv_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_WIDTH), .AW(CW)) u_lb0 (
        .clk     (clk),
        .we      (wr_en),
        .addr    (col),
        .wr_data (Data_In),
        .rd_data (lb0_rd)
    );

    conv_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_WIDTH), .AW(CW)) u_lb1 (
        .clk     (clk),
        .we      (wr_en),
        .addr    (col),
        .wr_data (lb0_rd),
        .rd_data (lb1_rd)
    );

    assign new_col[0] = lb1_rd;
    assign new_col[1] = lb0_rd;
    assign new_col[2] = Data_In;

    assign last_pix = (row == ROW_LAST) && (col == COL_LAST);

`ifdef CONV_WINDOW_STRIDE2_EN
    // (row-2) and (col-2) share parity with row and col.
    assign issue = (row >= ROW_FIRST) && (col >= COL_FIRST) && !row[0] && !col[0];
`else
    assign issue = (row >= ROW_FIRST) && (col >= COL_FIRST);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            Valid_Out  <= 1'b0;
            Frame_Done <= 1'b0;
            for (int c = 0; c < KERNEL_SIZE - 1; c++) begin
                for (int r = 0; r < KERNEL_SIZE; r++) begin
                    sr[c][r] <= '0;
                end
            end
            for (int k = 0; k < KERNEL_SIZE * KERNEL_SIZE; k++) begin
                win[k] <= '0;
            end
        end else begin
            Valid_Out  <= Valid_In && issue;
            Frame_Done <= Valid_In && last_pix;
            if (Valid_In) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                for (int r = 0; r < KERNEL_SIZE; r++) begin
                    sr[0][r] <= sr[1][r];
                    sr[1][r] <= new_col[r];
                end
                if (issue) begin
                    for (int r = 0; r < KERNEL_SIZE; r++) begin
                        win[r*KERNEL_SIZE + 0] <= sr[0][r];
                        win[r*KERNEL_SIZE + 1] <= sr[1][r];
                        win[r*KERNEL_SIZE + 2] <= new_col[r];
                    end
                end
            end
        end
    end

    assign Window0 = win[WIN_TL];
    assign Window1 = win[WIN_TC];
    assign Window2 = win[WIN_TR];
    assign Window3 = win[WIN_ML];
    assign Window4 = win[WIN_MC];
    assign Window5 = win[WIN_MR];
    assign Window6 = win[WIN_BL];
    assign Window7 = win[WIN_BC];
    assign Window8 = win[WIN_BR];

endmodule

`default_nettype wire

// File: tb/tb_conv_window_3x3_gen.sv
// ============================================================================
// Module : tb_conv_window_3x3_gen
// Brief  : Self-checking bench for conv_window_3x3_gen on a 5x5 image.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_conv_window_3x3_gen;

    localparam int DW = 32;
    localparam int W  = 5;
    localparam int H  = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          Valid_In = 1'b0;
    logic [DW-1:0] Data_In = '0;
    logic [DW-1:0] w0, w1, w2, w3, w4, w5, w6, w7, w8;
    logic          Valid_Out;
    logic          Frame_Done;
    logic [9*DW-1:0] dut_win;

    always #5 clk = ~clk;

    conv_window_3x3_gen #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .Data_In    (Data_In),
        .Valid_In   (Valid_In),
        .Window0    (w0),
        .Window1    (w1),
        .Window2    (w2),
        .Window3    (w3),
        .Window4    (w4),
        .Window5    (w5),
        .Window6    (w6),
        .Window7    (w7),
        .Window8    (w8),
        .Valid_Out  (Valid_Out),
        .Frame_Done (Frame_Done)
    );

    assign dut_win = {w0, w1, w2, w3, w4, w5, w6, w7, w8};

    int n_cmp  = 0;
    int n_fail = 0;
    int fd_cnt = 0;
    logic chk_en = 1'b0;
    logic [9*DW-1:0] cap [$];

    task automatic check(input string nm, input logic [9*DW-1:0] act, input logic [9*DW-1:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    function automatic logic [9*DW-1:0] mk(input int a0, input int a1, input int a2,
                                           input int a3, input int a4, input int a5,
                                           input int a6, input int a7, input int a8);
        return {DW'(a0), DW'(a1), DW'(a2), DW'(a3), DW'(a4), DW'(a5), DW'(a6), DW'(a7), DW'(a8)};
    endfunction

    // Image-geometry model: remember each pixel at its (row, col) and cut windows from it.
    logic [DW-1:0]   img [H][W];
    int              mr = 0;
    int              mc = 0;
    logic            exp_v = 1'b0;
    logic            exp_fd = 1'b0;
    logic [9*DW-1:0] exp_win = '0;

    always @(posedge clk) begin
        bit iss;
        if (rst) begin
            mr = 0; mc = 0; exp_v = 1'b0; exp_fd = 1'b0; exp_win = '0;
        end else if (Valid_In) begin
            img[mr][mc] = Data_In;
            iss = (mr >= 2) && (mc >= 2);
`ifdef CONV_WINDOW_STRIDE2_EN
            iss = iss && ((mr - 2) % 2 == 0) && ((mc - 2) % 2 == 0);
`endif
            if (iss) begin
                for (int k = 0; k < 9; k++) begin
                    exp_win[(8-k)*DW +: DW] = img[mr-2+k/3][mc-2+k%3];
                end
            end
            exp_v  = iss;
            exp_fd = (mr == H-1) && (mc == W-1);
            if (mc == W-1) begin
                mc = 0;
                mr = (mr == H-1) ? 0 : mr + 1;
            end else begin
                mc = mc + 1;
            end
        end else begin
            exp_v = 1'b0; exp_fd = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("valid_out", {287'd0, Valid_Out}, {287'd0, exp_v});
            check("frame_done", {287'd0, Frame_Done}, {287'd0, exp_fd});
            check("window", dut_win, exp_win);
            if (Valid_Out === 1'b1) cap.push_back(dut_win);
            if (Frame_Done === 1'b1) fd_cnt++;
        end
    end

    task automatic pix(input int v);
        @(negedge clk); #1;
        Valid_In = 1'b1;
        Data_In  = DW'(v);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk); #1;
            Valid_In = 1'b0;
        end
    endtask

    task automatic frame(input int base, input int gap);
        for (int i = 1; i <= W*H; i++) begin
            pix(base + i);
            if (gap > 0) idle(gap);
        end
        idle(2);
    endtask

    task automatic clr();
        cap.delete();
        fd_cnt = 0;
    endtask

    task automatic check_frame(input string nm, input int base);
        logic [9*DW-1:0] first_w;
        logic [9*DW-1:0] last_w;
`ifdef CONV_WINDOW_STRIDE2_EN
        int br[4];
        br = '{13, 15, 23, 25};
        check({nm, "_count"}, 288'(cap.size()), 288'(4));
        for (int i = 0; i < 4 && i < cap.size(); i++) begin
            check({nm, "_br"}, 288'(cap[i][DW-1:0]), 288'(base + br[i]));
        end
`else
        check({nm, "_count"}, 288'(cap.size()), 288'(9));
`endif
        first_w = (cap.size() > 0) ? cap[0] : '0;
        last_w  = (cap.size() > 0) ? cap[cap.size()-1] : '0;
        check({nm, "_first"}, first_w, mk(base+1, base+2, base+3, base+6, base+7, base+8,
                                          base+11, base+12, base+13));
        check({nm, "_last"}, last_w, mk(base+13, base+14, base+15, base+18, base+19, base+20,
                                        base+23, base+24, base+25));
        check({nm, "_fd"}, 288'(fd_cnt), 288'(1));
    endtask

    initial begin
        logic [9*DW-1:0] sel;
        repeat (2) @(negedge clk);
        check("reset_valid", {287'd0, Valid_Out}, 288'd0);
        check("reset_fd", {287'd0, Frame_Done}, 288'd0);
        check("reset_window", dut_win, '0);
        chk_en = 1'b1;
        #1 rst = 1'b0;

        // Back-to-back frame
        frame(0, 0);
        check_frame("t1", 0);
        clr();

        // Gapped frame
        frame(0, 3);
        check_frame("t2", 0);
        clr();

        // Row boundary
        for (int i = 1; i <= 18; i++) pix(i);
        idle(2);
`ifdef CONV_WINDOW_STRIDE2_EN
        check("t3_count", 288'(cap.size()), 288'(2));
        sel = (cap.size() > 1) ? cap[1] : '0;
        check("t3_br", 288'(sel[DW-1:0]), 288'(15));
`else
        check("t3_count", 288'(cap.size()), 288'(4));
        sel = (cap.size() > 3) ? cap[3] : '0;
        check("t3_win18", sel, mk(6, 7, 8, 11, 12, 13, 16, 17, 18));
`endif
        for (int i = 19; i <= 25; i++) pix(i);
        idle(2);
        clr();

        // Abort mid-frame with reset, a pixel offered during reset is discarded
        for (int i = 1; i <= 17; i++) pix(i);
        @(negedge clk); #1;
        rst = 1'b1; Valid_In = 1'b1; Data_In = DW'(999);
        @(negedge clk); #1;
        rst = 1'b0; Valid_In = 1'b0;
        idle(2);
        check("t4_abort_fd", 288'(fd_cnt), 288'(0));
        clr();
        frame(100, 0);
        check_frame("t4", 100);
        clr();

        // Two frames back-to-back
        for (int i = 1; i <= W*H; i++) pix(200 + i);
        frame(300, 0);
`ifdef CONV_WINDOW_STRIDE2_EN
        check("t5_count", 288'(cap.size()), 288'(8));
        sel = (cap.size() > 4) ? cap[4] : '0;
`else
        check("t5_count", 288'(cap.size()), 288'(18));
        sel = (cap.size() > 9) ? cap[9] : '0;
`endif
        check("t5_fd", 288'(fd_cnt), 288'(2));
        check("t5_second_first", sel, mk(301, 302, 303, 306, 307, 308, 311, 312, 313));

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
